adc_scan_ctrl: RTL

- Emulates the game board's 4-channel, 8-bit analog-to-digital converter (ADC) that the CPU uses to read the two trackball/analog sticks (AX0, AY0, AX1, AY1).
- The CPU strobes a channel select/start; the block samples and holds the chosen stick value, runs a fixed conversion time, raises end-of-conversion, then presents the result on a latched read port.
- Sits inside FPGA_FoodFight between the top-level stick values and the CPU address decoder.

---
 rtl/fdf_adc_pkg.sv | 11 +
 rtl/adc_conv_timer.sv | 42 ++++
 rtl/adc_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fdf_adc_pkg.sv
// Shared types and defaults for the stick ADC emulation.
package fdf_adc_pkg;

  typedef enum logic [1:0] {CH_AX0, CH_AY0, CH_AX1, CH_AY1} adc_ch_e;

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} adc_st_e;

  localparam int         DEF_CONV_TICKS = 64;
  localparam logic [7:0] DEF_IDLE_VAL   = 8'h80;

endpackage

// File: rtl/adc_conv_timer.sv
// Conversion timer: clearable counter advanced by the ADC clock enable.
// tc is combinational and is high in the cycle the final enabled tick
// arrives, so the controller can leave CONV on that same edge.
module adc_conv_timer
  import fdf_adc_pkg::*;
#(
  parameter int CONV_TICKS = DEF_CONV_TICKS
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int           W    = $clog2(CONV_TICKS) + 1;
  localparam logic [W-1:0] LAST = W'(CONV_TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == LAST);

  // Next count: clear wins, then increment; parks on LAST so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// 4-channel 8-bit stick ADC emulation: CPU start strobe, sample-and-hold,
// fixed CE-timed conversion, end-of-conversion flag and latched result.
// Optional macro ADC_AVG_EN: average each result with that channel's
// previous raw sample.
module adc_scan_ctrl
  import fdf_adc_pkg::*;
#(
  parameter int         CONV_TICKS = DEF_CONV_TICKS,
  parameter logic [7:0] IDLE_VAL   = DEF_IDLE_VAL
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic [7:0] AX0,
  input  logic [7:0] AY0,
  input  logic [7:0] AX1,
  input  logic [7:0] AY1,
  input  logic       ST,
  input  logic [1:0] CH,
  output logic [7:0] DOUT,
  output logic       EOC,
  output logic       BUSY
);

  adc_st_e    state_q, state_d;
  adc_ch_e    chan_q, chan_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] dout_q, dout_d;
  logic       eoc_q, eoc_d;
  logic [7:0] sel_val;
  logic [7:0] result;
  logic       tmr_clr, tmr_en, tmr_tc;

  adc_conv_timer #(.CONV_TICKS(CONV_TICKS)) u_timer (
    .MCLK (MCLK),
    .RESET(RESET),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

  // Stick selection for the sample-and-hold.
  always_comb begin
    sel_val = AX0;
    case (chan_q)
      CH_AX0:  sel_val = AX0;
      CH_AY0:  sel_val = AY0;
      CH_AX1:  sel_val = AX1;
      CH_AY1:  sel_val = AY1;
      default: sel_val = AX0;
    endcase
  end

`ifdef ADC_AVG_EN
  logic [7:0] hist_q [4];
  logic [7:0] hist_d [4];
  logic [8:0] avg_sum;

  // Rounded mean of new sample and channel history; history keeps the raw sample.
  always_comb begin
    hist_d  = hist_q;
    avg_sum = {1'b0, hold_q} + {1'b0, hist_q[chan_q]} + 9'd1;
    result  = avg_sum[8:1];
    if (state_q == S_DONE) begin
      hist_d[chan_q] = hold_q;
    end
  end

  // Per-channel history registers.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= IDLE_VAL;
      end
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign result = hold_q;
`endif

  // Conversion sequencer: a new start always wins, including over terminal count.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    eoc_d   = eoc_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ST) begin
          chan_d  = adc_ch_e'(CH);
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        hold_d  = sel_val;
        tmr_clr = 1'b1;
        eoc_d   = 1'b0;
        state_d = S_CONV;
        if (ST) begin
          chan_d  = adc_ch_e'(CH);
          state_d = S_SAMPLE;
        end
      end
      S_CONV: begin
        tmr_en = CE;
        if (ST) begin
          chan_d  = adc_ch_e'(CH);
          state_d = S_SAMPLE;
        end else if (tmr_tc) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dout_d  = result;
        eoc_d   = 1'b1;
        state_d = S_IDLE;
        if (ST) begin
          chan_d  = adc_ch_e'(CH);
          state_d = S_SAMPLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and result registers.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      chan_q  <= CH_AX0;
      hold_q  <= '0;
      dout_q  <= IDLE_VAL;
      eoc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      eoc_q   <= eoc_d;
    end
  end

  assign DOUT = dout_q;
  assign EOC  = eoc_q;
  assign BUSY = (state_q != S_IDLE);

endmodule
